// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared types and helpers for the counter_seq scheduler.
//   state_t  : scheduler FSM states (IDLE, COUNT, DONE)
//   pick_t   : round-robin pick result (valid flag + winner index)
//   rr_pick  : round-robin arbiter starting at ptr, for up to MAX_NREQ requesters
package counter_seq_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned MAX_NREQ  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // First requester found scanning upward from ptr, wrapping at nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [2:0]          ptr,
                                    input int unsigned         nreq);
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      i = (32'(ptr) + k) % nreq;
      if (k < nreq && !p.valid && req[i[2:0]]) begin
        p.valid = 1'b1;
        p.idx   = i[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/counter_seq_interval_counter.sv
// interval_counter: shared down-counting interval timer datapath.
//   clk, rst       : clock, synchronous active-high reset
//   load, load_val : load a new interval
//   dec            : decrement by one (holds at zero, never wraps)
//   clr            : clear to zero
//   count          : live counter value
//   at_one         : count == 1 (terminal count on the next decrement)
module interval_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_one
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign at_one = (count == WIDTH'(1));

endmodule

// File: rtl/counter_seq.sv
// counter_seq: round-robin scheduler sharing one interval timer among NREQ
// requesters. Grants one requester, loads its len, counts down, and pulses
// that requester's done at terminal count.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request level (held until done)
//   len      : per-requester interval, requester i at [i*WIDTH +: WIDTH]
//   gnt      : registered one-hot grant
//   done     : one-cycle completion pulse to the grantee (combinational)
//   busy     : state is not IDLE
//   owner    : index of current or last grantee
//   count    : live counter value
// Optional build macro: SEQ_ABORT_EN -- a grantee dropping req during COUNT
// aborts the interval without a done pulse.
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned OW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      count
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_d;
  logic [OW-1:0]    owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  pick_t            pick;
  logic [OW-1:0]    win;
  logic [WIDTH-1:0] len_sel;
  logic             load, dec, clr, at_one, abort;

  interval_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (len_sel),
    .dec      (dec),
    .clr      (clr),
    .count    (count),
    .at_one   (at_one)
  );

  always_comb begin
    pick    = rr_pick(MAX_NREQ'(req), 3'(ptr_q), NREQ);
    win     = pick.idx[OW-1:0];
    len_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == 3'(i)) len_sel = len[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    abort = 1'b0;
`ifdef SEQ_ABORT_EN
    abort = !req[owner];
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    owner_d = owner;
    ptr_d   = ptr_q;
    load    = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick.valid) begin
          load    = 1'b1;
          gnt_d   = NREQ'(1) << win;
          owner_d = win;
          ptr_d   = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
          state_d = (len_sel != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        if (abort) begin
          clr     = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          dec = 1'b1;
          if (at_one) state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign done = (state_q == DONE) ? (NREQ'(1) << owner) : '0;
  assign busy = (state_q != IDLE);

endmodule
